fp_align_stage: RTL and testbench

- Pre-adder operand alignment stage; sits directly upstream of FP_Adder's add/normalise datapath.
- Accepts two IEEE-754 single-precision operands and unpacks them.
- Orders them by magnitude and right-shifts the smaller significand with guard/round/sticky bits.
- Emits aligned operands, effective-operation and special-case flags over a 2-deep valid/ready pipeline.

---
 rtl/fp_pkg.sv | 63 ++++++
 rtl/fp_sticky_shifter.sv | 30 +++
 rtl/fp_align_stage.sv | 125 ++++++++++++
 tb/tb_fp_align_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared widths, operand types and special-case classification for the FP alignment stage.
// FP_ALIGN_SUBNORMAL_EN selects gradual underflow; otherwise exp=0 operands are flushed to zero.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int SIG_W  = MANT_W + 4;
    localparam int FP_W   = 1 + EXP_W + MANT_W;

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp_unpacked_t;

    typedef struct packed {
        logic is_nan;
        logic is_inf;
        logic is_zero;
    } fp_class_t;

    function automatic fp_class_t fp_classify(input logic [FP_W-1:0] word);
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] f;
        fp_class_t         c;
        e         = word[FP_W-2 -: EXP_W];
        f         = word[MANT_W-1:0];
        c.is_nan  = (e == EXP_ALL_ONES) && (f != '0);
        c.is_inf  = (e == EXP_ALL_ONES) && (f == '0);
`ifdef FP_ALIGN_SUBNORMAL_EN
        c.is_zero = (e == '0) && (f == '0);
`else
        c.is_zero = (e == '0);
`endif
        return c;
    endfunction

    // sig carries {hidden, fraction, G, R, S}; exp is the effective exponent.
    function automatic fp_unpacked_t fp_unpack(input logic [FP_W-1:0] word);
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] f;
        fp_unpacked_t      u;
        e      = word[FP_W-2 -: EXP_W];
        f      = word[MANT_W-1:0];
        u.sign = word[FP_W-1];
        if (e == '0) begin
`ifdef FP_ALIGN_SUBNORMAL_EN
            u.exp = EXP_W'(1);
            u.sig = {1'b0, f, 3'b000};
`else
            u.exp = '0;
            u.sig = '0;
`endif
        end else begin
            u.exp = e;
            u.sig = {1'b1, f, 3'b000};
        end
        return u;
    endfunction

endpackage

// File: rtl/fp_sticky_shifter.sv
// Combinational right shift of an aligned significand; every bit shifted out is ORed into the LSB.
// Shift amounts of SIG_W or more collapse the whole operand into the sticky bit.
module fp_sticky_shifter
    import fp_pkg::*;
(
    input  logic [SIG_W-1:0] sig,
    input  logic [EXP_W-1:0] amt,
    output logic [SIG_W-1:0] result
);

    logic [SIG_W-1:0] shifted;
    logic [SIG_W-1:0] lost_mask;
    logic             sticky;

    always_comb begin
        shifted   = '0;
        lost_mask = '0;
        sticky    = 1'b0;
        result    = '0;
        if (amt >= EXP_W'(SIG_W)) begin
            result = {{(SIG_W-1){1'b0}}, |sig};
        end else begin
            shifted   = sig >> amt;
            lost_mask = ~({SIG_W{1'b1}} << amt);
            sticky    = |(sig & lost_mask);
            result    = {shifted[SIG_W-1:1], shifted[0] | sticky};
        end
    end

endmodule

// File: rtl/fp_align_stage.sv
// Operand alignment ahead of the FP adder: unpack, order by magnitude, sticky right-shift.
// Two registered valid/ready stages; FP_ALIGN_SUBNORMAL_EN enables subnormal operands.
module fp_align_stage
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  N1,
    input  logic [FP_W-1:0]  N2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_big,
    output logic             eff_sub,
    output logic             swapped,
    output logic [EXP_W-1:0] exp_big,
    output logic [SIG_W-1:0] sig_big,
    output logic [SIG_W-1:0] sig_small,
    output logic             zero_flag,
    output logic             inf_flag,
    output logic             nan_flag
);

    fp_unpacked_t op_a, op_b, op_big, op_small;
    fp_class_t    cls_a, cls_b;
    logic         swap_c, nan_c, inf_c, zero_c;

    always_comb begin
        op_a     = fp_unpack(N1);
        op_b     = fp_unpack(N2);
        cls_a    = fp_classify(N1);
        cls_b    = fp_classify(N2);
        // {exp, sig} is monotonic in magnitude in both underflow modes; ties keep N1 on top
        swap_c   = {op_b.exp, op_b.sig} > {op_a.exp, op_a.sig};
        op_big   = swap_c ? op_b : op_a;
        op_small = swap_c ? op_a : op_b;
        nan_c    = cls_a.is_nan | cls_b.is_nan
                 | (cls_a.is_inf & cls_b.is_inf & (N1[FP_W-1] ^ N2[FP_W-1]));
        inf_c    = (cls_a.is_inf | cls_b.is_inf) & ~nan_c;
        zero_c   = cls_a.is_zero & cls_b.is_zero;
    end

    logic s1_valid;
    logic s1_advance, s2_advance, accept;

    assign s2_advance = ~out_valid | out_ready;
    assign s1_advance = s2_advance | ~out_valid;
    assign in_ready   = ~s1_valid | s1_advance;
    assign accept     = in_valid & in_ready;

    logic             s1_sign_big, s1_eff_sub, s1_swapped;
    logic [EXP_W-1:0] s1_exp_big, s1_diff;
    logic [SIG_W-1:0] s1_sig_big, s1_sig_small;
    logic             s1_zero, s1_inf, s1_nan;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_sign_big  <= 1'b0;
            s1_eff_sub   <= 1'b0;
            s1_swapped   <= 1'b0;
            s1_exp_big   <= '0;
            s1_diff      <= '0;
            s1_sig_big   <= '0;
            s1_sig_small <= '0;
            s1_zero      <= 1'b0;
            s1_inf       <= 1'b0;
            s1_nan       <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid     <= 1'b1;
                s1_sign_big  <= op_big.sign;
                s1_eff_sub   <= N1[FP_W-1] ^ N2[FP_W-1];
                s1_swapped   <= swap_c;
                s1_exp_big   <= op_big.exp;
                s1_diff      <= op_big.exp - op_small.exp;
                s1_sig_big   <= op_big.sig;
                s1_sig_small <= op_small.sig;
                s1_zero      <= zero_c;
                s1_inf       <= inf_c;
                s1_nan       <= nan_c;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    logic [SIG_W-1:0] aligned_small;

    fp_sticky_shifter u_shift (
        .sig    (s1_sig_small),
        .amt    (s1_diff),
        .result (aligned_small)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sign_big  <= 1'b0;
            eff_sub   <= 1'b0;
            swapped   <= 1'b0;
            exp_big   <= '0;
            sig_big   <= '0;
            sig_small <= '0;
            zero_flag <= 1'b0;
            inf_flag  <= 1'b0;
            nan_flag  <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sign_big  <= s1_sign_big;
                eff_sub   <= s1_eff_sub;
                swapped   <= s1_swapped;
                exp_big   <= s1_exp_big;
                sig_big   <= s1_sig_big;
                sig_small <= aligned_small;
                zero_flag <= s1_zero;
                inf_flag  <= s1_inf;
                nan_flag  <= s1_nan;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_stage.sv
// Scoreboard bench for fp_align_stage: random and directed operand pairs against an arithmetic model.
// Build with FP_ALIGN_SUBNORMAL_EN to exercise the subnormal variant of the model and design.
module tb_fp_align_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] N1, N2;
    logic        sign_big, eff_sub, swapped, zero_flag, inf_flag, nan_flag;
    logic [7:0]  exp_big;
    logic [26:0] sig_big, sig_small;

    fp_align_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .N1(N1), .N2(N2), .out_valid(out_valid), .out_ready(out_ready),
        .sign_big(sign_big), .eff_sub(eff_sub), .swapped(swapped),
        .exp_big(exp_big), .sig_big(sig_big), .sig_small(sig_small),
        .zero_flag(zero_flag), .inf_flag(inf_flag), .nan_flag(nan_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sign_big;
        logic        eff_sub;
        logic        swapped;
        logic [7:0]  exp_big;
        logic [26:0] sig_big;
        logic [26:0] sig_small;
        logic        zero_flag;
        logic        inf_flag;
        logic        nan_flag;
    } res_t;

    typedef struct {
        res_t r;
        int   acc_cyc;
        bit   chk_lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic res_t cur();
        res_t r;
        r = '{sign_big, eff_sub, swapped, exp_big, sig_big, sig_small, zero_flag, inf_flag, nan_flag};
        return r;
    endfunction

    // Reference: magnitude from the raw bit pattern, significands as integers, alignment by division.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t            r;
        int unsigned     ea, eb, fa, fb, key_a, key_b, xa, xb, diff;
        longint unsigned ma, mb, sm, sm_out, rem;
        bit              b_big, nan_a, nan_b, inf_a, inf_b, nan_r;
        ea = a[30:23]; fa = a[22:0];
        eb = b[30:23]; fb = b[22:0];
`ifdef FP_ALIGN_SUBNORMAL_EN
        key_a = a[30:0];
        key_b = b[30:0];
        xa = (ea == 0) ? 1 : ea;
        xb = (eb == 0) ? 1 : eb;
        ma = (ea == 0) ? fa : fa + 8388608;
        mb = (eb == 0) ? fb : fb + 8388608;
        r.zero_flag = (a[30:0] == 0) && (b[30:0] == 0);
`else
        key_a = (ea == 0) ? 0 : a[30:0];
        key_b = (eb == 0) ? 0 : b[30:0];
        xa = ea;
        xb = eb;
        ma = (ea == 0) ? 0 : fa + 8388608;
        mb = (eb == 0) ? 0 : fb + 8388608;
        r.zero_flag = (ea == 0) && (eb == 0);
`endif
        b_big = key_b > key_a;
        diff  = b_big ? xb - xa : xa - xb;
        sm    = (b_big ? ma : mb) * 8;
        if (diff >= 27) begin
            sm_out = (sm != 0) ? 1 : 0;
        end else begin
            rem    = sm % (64'd1 << diff);
            sm_out = (sm >> diff) | ((rem != 0) ? 1 : 0);
        end
        nan_a = (ea == 255) && (fa != 0);
        nan_b = (eb == 255) && (fb != 0);
        inf_a = (ea == 255) && (fa == 0);
        inf_b = (eb == 255) && (fb == 0);
        nan_r = nan_a || nan_b || (inf_a && inf_b && (a[31] != b[31]));
        r.nan_flag  = nan_r;
        r.inf_flag  = (inf_a || inf_b) && !nan_r;
        r.sign_big  = b_big ? b[31] : a[31];
        r.eff_sub   = a[31] ^ b[31];
        r.swapped   = b_big;
        r.exp_big   = 8'(b_big ? xb : xa);
        r.sig_big   = 27'((b_big ? mb : ma) * 8);
        r.sig_small = 27'(sm_out);
        return r;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom % 10;
        case (k)
            0: w[30:0]  = '0;
            1: w[30:23] = '0;
            2: w[30:0]  = {8'hFF, 23'h0};
            3: begin
                w[30:23] = 8'hFF;
                if (w[22:0] == '0) w[0] = 1'b1;
            end
            default: ;
        endcase
        return w;
    endfunction

    // ordy_mode: 0 = out_ready high, 1 = random, 2 = out_ready low
    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                         input int ordy_mode, input bit lat, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        N1        = a;
        N2        = b;
        out_ready = (ordy_mode == 0) ? 1'b1 : (ordy_mode == 2) ? 1'b0 : (($urandom % 4) != 0);
        #1;
        acc = v && in_ready;
        if (acc) begin
            e.r       = model(a, b);
            e.acc_cyc = cyc;
            e.chk_lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input int ordy_mode, input bit lat);
        bit acc;
        int t;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 50) begin
            drive(1'b1, a, b, ordy_mode, lat, acc);
            t++;
        end
        if (!acc) fail_now("send_timeout");
    endtask

    task automatic idle(input int n, input int ordy_mode);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom, ordy_mode, 1'b0, acc);
    endtask

    task automatic direct(input logic [31:0] a, input logic [31:0] b);
        send(a, b, 0, 1'b1);
        idle(2, 0);
        check("direct_out_valid", 128'(out_valid), 128'(1));
    endtask

    bit   prev_stall = 1'b0;
    res_t prev_r;
    exp_t mon_e;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 128'(out_valid), 128'(1));
                check("hold_data", 128'(cur()), 128'(prev_r));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: actual=%0h required=none", cur());
                end else begin
                    mon_e = sb.pop_front();
                    check("data", 128'(cur()), 128'(mon_e.r));
                    if (mon_e.chk_lat) check("latency", 128'(cyc - mon_e.acc_cyc), 128'(2));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_r     = cur();
        end
    end

    logic [31:0] pa[4], pb[4];

    initial begin
        bit          acc;
        int          idx;
        logic [31:0] a, b;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; N1 = '0; N2 = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_outputs", 128'(cur()), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_reset_in_ready", 128'(in_ready), 128'(1));

        // Directed pairs: the scoreboard checks every field, the constants pin known encodings.
        direct(32'h41CA0000, 32'hC1CA0000);
        check("p1_exp_big", 128'(exp_big), 128'(8'h83));
        check("p1_sig_small", 128'(sig_small), 128'(27'h6500000));
        check("p1_eff_sub", 128'(eff_sub), 128'(1));
        direct(32'h3FC00000, 32'h41CA0000);
        check("p2_swapped", 128'(swapped), 128'(1));
        check("p2_sig_small", 128'(sig_small), 128'(27'h0600000));
        direct(32'h4E5719EB, 32'h33C1BEF8);
        check("p3_exp_big", 128'(exp_big), 128'(8'h9C));
        check("p3_sig_small_sat", 128'(sig_small), 128'(27'h0000001));
        direct(32'h7F800000, 32'hFF800000);
        check("p4_nan", 128'({nan_flag, inf_flag}), 128'(2'b10));
        direct(32'h7F800000, 32'h3F800000);
        check("p5_inf", 128'({nan_flag, inf_flag}), 128'(2'b01));
        direct(32'h00000001, 32'h00000001);
`ifdef FP_ALIGN_SUBNORMAL_EN
        check("p6_sub_sig_big", 128'(sig_big), 128'(27'h0000008));
        check("p6_sub_zero", 128'(zero_flag), 128'(0));
`else
        check("p6_daz_zero", 128'(zero_flag), 128'(1));
`endif
        idle(2, 0);

        // Four back-to-back pairs with the consumer stalled for three cycles.
        for (int i = 0; i < 4; i++) begin
            pa[i] = gen();
            pb[i] = gen();
        end
        idx = 0;
        for (int c = 0; c < 30 && !(idx == 4 && sb.size() == 0); c++) begin
            drive(idx < 4, pa[idx % 4], pb[idx % 4], (c >= 2 && c <= 4) ? 2 : 0, 1'b0, acc);
            if (c == 2) begin
                check("stall_in_ready", 128'(in_ready), 128'(0));
                check("stall_accepts", 128'(idx), 128'(2));
            end
            if (acc) idx++;
        end
        check("stall_drain", 128'(sb.size()), 128'(0));

        // Reset with two pairs in flight: nothing may come out afterwards.
        send(gen(), gen(), 2, 1'b0);
        send(gen(), gen(), 2, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_outputs", 128'(cur()), 128'(0));
        rst = 1'b0;
        idle(5, 0);
        check("midrst_in_ready", 128'(in_ready), 128'(1));

        // Random traffic with random back-pressure and gaps.
        for (int n = 0; n < 400; n++) begin
            if (($urandom % 5) == 0) begin
                idle(1, 1);
            end else begin
                a = gen();
                b = gen();
                case ($urandom % 4)
                    0: b[30:23] = a[30:23] + 8'($urandom % 8) - 8'd4;
                    1: b[30:0]  = a[30:0];
                    default: ;
                endcase
                send(a, b, 1, 1'b0);
            end
        end

        begin
            int t;
            t = 0;
            while (sb.size() != 0 && t < 100) begin
                idle(1, 0);
                t++;
            end
            if (sb.size() != 0) fail_now("final_drain");
        end
        idle(3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
